// File: rtl/div_fsm_pkg.sv
// Shared types for the multi-cycle restoring divider.
package div_fsm_pkg;

    localparam int unsigned DIV_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_fsm_if.sv
// Request/result bundle of the divider: en/ready accept handshake plus vld_out result strobe.
interface div_fsm_if #(
    parameter int unsigned DATAWIDTH = 16
);

    logic                 en;
    logic                 ready;
    logic [DATAWIDTH-1:0] dividend;
    logic [DATAWIDTH-1:0] divisor;
    logic [DATAWIDTH-1:0] quotient;
    logic [DATAWIDTH-1:0] remainder;
    logic                 vld_out;

    modport master (
        output en,
        output dividend,
        output divisor,
        input  ready,
        input  quotient,
        input  remainder,
        input  vld_out
    );

    modport slave (
        input  en,
        input  dividend,
        input  divisor,
        output ready,
        output quotient,
        output remainder,
        output vld_out
    );

endinterface

// File: rtl/div_fsm.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// Divide by zero falls out of the algorithm: quotient = all ones, remainder = dividend.
module div_fsm
    import div_fsm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rstn,
    div_fsm_if.slave  bus
);

    localparam int unsigned   CW        = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATAWIDTH - 1);

    div_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] dq_q, dq_d;
    logic [DATAWIDTH-1:0] r_q, r_d;
    logic [DATAWIDTH-1:0] dvsr_q, dvsr_d;
    logic [DATAWIDTH-1:0] quot_q, quot_d;
    logic [DATAWIDTH-1:0] rem_q, rem_d;

    logic [DATAWIDTH:0]   r_shift;
    logic                 q_bit;
    logic [DATAWIDTH-1:0] r_next;
    logic [DATAWIDTH-1:0] dq_next;

    // Compare is W+1 wide; when it passes the difference always fits in W bits.
    always_comb begin
        r_shift = {r_q, dq_q[DATAWIDTH-1]};
        q_bit   = (r_shift >= {1'b0, dvsr_q});
        r_next  = q_bit ? (r_shift[DATAWIDTH-1:0] - dvsr_q) : r_shift[DATAWIDTH-1:0];
        dq_next = {dq_q[DATAWIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        r_d     = r_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    dq_d    = bus.dividend;
                    dvsr_d  = bus.divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                dq_d  = dq_next;
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                // Final step writes the result registers directly on the edge into DONE.
                if (cnt_q == LAST_STEP) begin
                    quot_d  = dq_next;
                    rem_d   = r_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            r_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            r_q     <= r_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.vld_out   = (state_q == DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;

endmodule

// File: tb/tb_div_fsm.sv
// Scoreboard bench for div_fsm: expected results queued at accept, compared at vld_out.
module tb_div_fsm;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int unsigned  acc;
    } exp_t;

    logic clk;
    logic rstn;

    div_fsm_if #(.DATAWIDTH(W)) bus ();

    div_fsm #(.DATAWIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned n_done   = 0;
    int unsigned prev_vld_cyc = 0;
    bit          have_prev    = 0;
    bit          check_period = 0;
    bit          vld_prev     = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned c);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        e.acc = c;
        return e;
    endfunction

    // Monitor: queue on accept cycle, compare on vld_out.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (vld_prev) check_eq("ready_after_vld", 32'(bus.ready), 32'd1);
            vld_prev <= bus.vld_out;
            if (bus.ready && bus.en) sb.push_back(model(bus.dividend, bus.divisor, cyc));
            if (bus.vld_out) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_vld", 32'(bus.vld_out), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("quotient", 32'(bus.quotient), 32'(e.q));
                    check_eq("remainder", 32'(bus.remainder), 32'(e.r));
                    check_eq("latency", cyc - e.acc, 32'd17);
                    if (check_period && have_prev) check_eq("period", cyc - prev_vld_cyc, 32'd18);
                    last_q <= e.q;
                    last_r <= e.r;
                end
                prev_vld_cyc <= cyc;
                have_prev    <= 1'b1;
                n_done       <= n_done + 1;
            end
        end else begin
            vld_prev <= 1'b0;
        end
    end

    task automatic wait_results(input int unsigned target);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (n_done >= target) break;
        end
        check_eq("done_count", n_done, target);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.dividend = a;
        bus.divisor  = b;
        bus.en       = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned target;
        target = n_done + 1;
        start_op(a, b);
        wait_results(target);
    endtask

    initial begin
        int unsigned target;
        int unsigned saved;
        int unsigned k;

        rstn         = 1'b0;
        bus.en       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.ready), 32'd1);
        check_eq("rst_vld", 32'(bus.vld_out), 32'd0);
        check_eq("rst_quot", 32'(bus.quotient), 32'd0);
        check_eq("rst_rem", 32'(bus.remainder), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        run_op(16'd1000, 16'd7);
        run_op(16'd5, 16'd9);
        run_op(16'd0, 16'd3);
        run_op(16'hFFFF, 16'd1);
        run_op(16'hFFFF, 16'hFFFF);
        run_op(16'd999, 16'd0);
        run_op(16'hFFFE, 16'hFFFF);
        run_op(16'hF000, 16'h8001);

        // Operand and en changes during CALC must not disturb the running operation.
        target = n_done + 1;
        start_op(16'd1234, 16'd11);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.dividend = 16'($urandom);
            bus.divisor  = 16'($urandom);
            bus.en       = ~bus.en;
        end
        bus.en = 1'b0;
        wait_results(target);

        saved = n_done;
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(bus.ready), 32'd1);
        end
        check_eq("idle_no_op", n_done, saved);

        // Back-to-back with en held high.
        check_period = 1'b1;
        have_prev    = 1'b0;
        target       = n_done + 10;
        for (int i = 0; i < 10; i++) begin
            k = 0;
            while (!bus.ready && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            bus.dividend = 16'($urandom_range(999, 0));
            bus.divisor  = 16'($urandom_range(99, 1));
            bus.en       = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.en = 1'b0;
        wait_results(target);
        check_period = 1'b0;

        repeat (20) begin
            @(negedge clk);
            check_eq("hold_quot", 32'(bus.quotient), 32'(last_q));
            check_eq("hold_rem", 32'(bus.remainder), 32'(last_r));
            check_eq("hold_vld", 32'(bus.vld_out), 32'd0);
        end

        // Reset in the middle of CALC.
        saved = n_done;
        start_op(16'd4000, 16'd3);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_eq("midrst_ready", 32'(bus.ready), 32'd1);
        check_eq("midrst_vld", 32'(bus.vld_out), 32'd0);
        check_eq("midrst_quot", 32'(bus.quotient), 32'd0);
        check_eq("midrst_rem", 32'(bus.remainder), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("midrst_no_vld", n_done, saved);
        check_eq("midrst_ready_after", 32'(bus.ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
